iob_axis_s_axi_m_write_int: RTL and testbench

IOB_AXIS_S_AXI_M_WRITE_INT -- requirements
Module: iob_axis_s_axi_m_write_int

---
 rtl/iob_axis_s_axi_m_write_int.sv | 194 +++++++++++++++++++
 tb/tb_iob_axis_s_axi_m_write_int.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/iob_axis_s_axi_m_write_int.sv
// rtl/iob_axis_s_axi_m_write_int.sv - AXI-Stream slave to AXI4 master write bridge
//
// Moves w_length_i words arriving on the AXIS input to memory starting at
// w_addr_i, splitting the transfer into INCR bursts that never cross a 4 KB page.
// Ports:
//   clk_i, cke_i, rst_i          clock, clock enable, synchronous active-high reset
//   w_addr_i, w_length_i         transfer start byte address and length in words
//   w_start_transfer_i           start pulse (ignored when busy or length is 0)
//   w_busy_o, w_error_o          transfer in progress; sticky non-OKAY bresp seen
//   axis_in_*                    stream input (data passes straight to wdata)
//   axi_aw*, axi_w*, axi_b*      AXI4 write address, data and response channels
module iob_axis_s_axi_m_write_int #(
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_DATA_W = 32,
   parameter int AXI_LEN_W  = 8,
   parameter int AXI_ID_W   = 1
) (
   input  logic                    clk_i,
   input  logic                    cke_i,
   input  logic                    rst_i,
   input  logic [AXI_ADDR_W-1:0]   w_addr_i,
   input  logic [AXI_LEN_W:0]      w_length_i,
   input  logic                    w_start_transfer_i,
   output logic                    w_busy_o,
   output logic                    w_error_o,
   input  logic [AXI_DATA_W-1:0]   axis_in_data_i,
   input  logic                    axis_in_valid_i,
   output logic                    axis_in_ready_o,
   output logic [AXI_ADDR_W-1:0]   axi_awaddr_o,
   output logic                    axi_awvalid_o,
   output logic [AXI_LEN_W-1:0]    axi_awlen_o,
   input  logic                    axi_awready_i,
   output logic [AXI_ID_W-1:0]     axi_awid_o,
   output logic [2:0]              axi_awsize_o,
   output logic [1:0]              axi_awburst_o,
   output logic [1:0]              axi_awlock_o,
   output logic [3:0]              axi_awcache_o,
   output logic [3:0]              axi_awqos_o,
   output logic [AXI_DATA_W-1:0]   axi_wdata_o,
   output logic [AXI_DATA_W/8-1:0] axi_wstrb_o,
   output logic                    axi_wlast_o,
   output logic                    axi_wvalid_o,
   input  logic                    axi_wready_i,
   input  logic [1:0]              axi_bresp_i,
   input  logic [AXI_ID_W-1:0]     axi_bid_i,
   input  logic                    axi_bvalid_i,
   output logic                    axi_bready_o
);

   typedef enum logic [1:0] {WAIT_START, START_BURST, TRANSF_DATA, WAIT_BRESP} state_t;

   state_t                state_q, state_d;
   logic [AXI_ADDR_W-1:0] addr_q, addr_d;
   logic [AXI_LEN_W-1:0]  awlen_q, awlen_d;
   logic [AXI_LEN_W-1:0]  beat_q, beat_d;
   logic [AXI_LEN_W:0]    remaining_q, remaining_d;
   logic                  awvalid_q, awvalid_d;
   logic                  bready_q, bready_d;
   logic                  busy_q, busy_d;
   logic                  error_q, error_d;

   logic [AXI_LEN_W:0]    awlen_p1;
   logic [AXI_ADDR_W-1:0] step;
   logic [AXI_ADDR_W-1:0] next_base;
   logic [AXI_LEN_W:0]    next_rem;
   logic [11:0]           to_bound;
   logic [11:0]           rem_ext;
   logic [AXI_LEN_W:0]    burst_words;
   logic [AXI_LEN_W-1:0]  awlen_new;
   logic                  w_hs;
   logic                  unused_sig;

   assign unused_sig = ^{axi_bid_i, w_addr_i[1:0]};

   // Next burst geometry: from the start inputs when idle, otherwise from the
   // address just past the finished burst and the words still outstanding.
   always_comb begin
      awlen_p1 = {1'b0, awlen_q} + {{AXI_LEN_W{1'b0}}, 1'b1};
      step     = {{(AXI_ADDR_W-AXI_LEN_W-3){1'b0}}, awlen_p1, 2'b00};
      if (state_q == WAIT_START) begin
         next_base = {w_addr_i[AXI_ADDR_W-1:2], 2'b00};
         next_rem  = w_length_i;
      end else begin
         next_base = addr_q + step;
         next_rem  = remaining_q;
      end
      // Words left before the 4 KB page ends (1..1024).
      to_bound    = 12'd1024 - {2'b00, next_base[11:2]};
      rem_ext     = {{(11-AXI_LEN_W){1'b0}}, next_rem};
      // When the page limit wins it is smaller than next_rem, so it fits.
      burst_words = (rem_ext <= to_bound) ? next_rem : to_bound[AXI_LEN_W:0];
      // A full 2^LEN_W burst wraps the low bits to 0, giving awlen all ones.
      awlen_new   = burst_words[AXI_LEN_W-1:0] - {{(AXI_LEN_W-1){1'b0}}, 1'b1};
   end

   assign w_hs = (state_q == TRANSF_DATA) && axis_in_valid_i && axi_wready_i;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      awlen_d     = awlen_q;
      beat_d      = beat_q;
      remaining_d = remaining_q;
      awvalid_d   = awvalid_q;
      error_d     = error_q;
      case (state_q)
         WAIT_START: begin
            if (w_start_transfer_i && (w_length_i != '0)) begin
               addr_d      = next_base;
               awlen_d     = awlen_new;
               remaining_d = next_rem - burst_words;
               error_d     = 1'b0;
               awvalid_d   = 1'b1;
               state_d     = START_BURST;
            end
         end
         START_BURST: begin
            if (axi_awready_i) begin
               awvalid_d = 1'b0;
               beat_d    = '0;
               state_d   = TRANSF_DATA;
            end
         end
         TRANSF_DATA: begin
            if (w_hs) begin
               beat_d = beat_q + {{(AXI_LEN_W-1){1'b0}}, 1'b1};
               if (beat_q == awlen_q) state_d = WAIT_BRESP;
            end
         end
         WAIT_BRESP: begin
            if (axi_bvalid_i) begin
               if (axi_bresp_i != 2'b00) error_d = 1'b1;
               if (remaining_q == '0) begin
                  state_d = WAIT_START;
               end else begin
                  addr_d      = next_base;
                  awlen_d     = awlen_new;
                  remaining_d = next_rem - burst_words;
                  awvalid_d   = 1'b1;
                  state_d     = START_BURST;
               end
            end
         end
         default: state_d = WAIT_START;
      endcase
      busy_d   = (state_d != WAIT_START);
      bready_d = (state_d == WAIT_BRESP);
   end

   always_ff @(posedge clk_i) begin
      if (cke_i) begin
         if (rst_i) begin
            state_q     <= WAIT_START;
            addr_q      <= '0;
            awlen_q     <= '0;
            beat_q      <= '0;
            remaining_q <= '0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
         end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            awlen_q     <= awlen_d;
            beat_q      <= beat_d;
            remaining_q <= remaining_d;
            awvalid_q   <= awvalid_d;
            bready_q    <= bready_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
         end
      end
   end

   assign w_busy_o        = busy_q;
   assign w_error_o       = error_q;
   assign axi_awaddr_o    = {addr_q[AXI_ADDR_W-1:2], 2'b00};
   assign axi_awvalid_o   = awvalid_q;
   assign axi_awlen_o     = awlen_q;
   assign axi_bready_o    = bready_q;
   assign axi_wdata_o     = axis_in_data_i;
   assign axi_wvalid_o    = (state_q == TRANSF_DATA) && axis_in_valid_i;
   assign axis_in_ready_o = (state_q == TRANSF_DATA) && axi_wready_i;
   assign axi_wlast_o     = (state_q == TRANSF_DATA) && (beat_q == awlen_q);
   assign axi_awid_o      = '0;
   assign axi_awsize_o    = 3'd2;
   assign axi_awburst_o   = 2'd1;
   assign axi_awlock_o    = 2'd0;
   assign axi_awcache_o   = 4'd2;
   assign axi_awqos_o     = 4'd0;
   assign axi_wstrb_o     = '1;

endmodule

// File: tb/tb_iob_axis_s_axi_m_write_int.sv
// tb/tb_iob_axis_s_axi_m_write_int.sv - scoreboard bench for the AXIS to AXI write bridge
module tb_iob_axis_s_axi_m_write_int;

   logic        clk_i = 1'b0;
   logic        cke_i, rst_i;
   logic [31:0] w_addr_i;
   logic [8:0]  w_length_i;
   logic        w_start_transfer_i;
   logic        w_busy_o, w_error_o;
   logic [31:0] axis_in_data_i;
   logic        axis_in_valid_i, axis_in_ready_o;
   logic [31:0] axi_awaddr_o;
   logic        axi_awvalid_o;
   logic [7:0]  axi_awlen_o;
   logic        axi_awready_i;
   logic [0:0]  axi_awid_o;
   logic [2:0]  axi_awsize_o;
   logic [1:0]  axi_awburst_o, axi_awlock_o;
   logic [3:0]  axi_awcache_o, axi_awqos_o;
   logic [31:0] axi_wdata_o;
   logic [3:0]  axi_wstrb_o;
   logic        axi_wlast_o, axi_wvalid_o, axi_wready_i;
   logic [1:0]  axi_bresp_i;
   logic [0:0]  axi_bid_i;
   logic        axi_bvalid_i, axi_bready_o;

   int passed = 0;
   int total  = 0;

   int          exp_aw[$];
   int          exp_len[$];
   logic [31:0] exp_d[$];
   logic [31:0] src[$];

   iob_axis_s_axi_m_write_int dut (
      .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i),
      .w_addr_i(w_addr_i), .w_length_i(w_length_i), .w_start_transfer_i(w_start_transfer_i),
      .w_busy_o(w_busy_o), .w_error_o(w_error_o),
      .axis_in_data_i(axis_in_data_i), .axis_in_valid_i(axis_in_valid_i),
      .axis_in_ready_o(axis_in_ready_o),
      .axi_awaddr_o(axi_awaddr_o), .axi_awvalid_o(axi_awvalid_o), .axi_awlen_o(axi_awlen_o),
      .axi_awready_i(axi_awready_i), .axi_awid_o(axi_awid_o), .axi_awsize_o(axi_awsize_o),
      .axi_awburst_o(axi_awburst_o), .axi_awlock_o(axi_awlock_o), .axi_awcache_o(axi_awcache_o),
      .axi_awqos_o(axi_awqos_o), .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
      .axi_wlast_o(axi_wlast_o), .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
      .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i), .axi_bvalid_i(axi_bvalid_i),
      .axi_bready_o(axi_bready_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      w_start_transfer_i = 1'b0;
      axis_in_valid_i    = 1'b0;
      axis_in_data_i     = '0;
      axi_awready_i      = 1'b0;
      axi_wready_i       = 1'b0;
      axi_bvalid_i       = 1'b0;
      axi_bresp_i        = 2'b00;
   endtask

   // One transfer: expected bursts and data go on the scoreboard when the
   // stimulus is set up and are popped as the DUT handshakes them.
   task automatic xfer(input int addr, input int len, input int gap,
                       input logic [1:0] bresp_v, input bit mid_start, input int rst_beat);
      int a, r, words, hs, cur_len, beat;
      bit b_pend, done;
      a = addr; r = len; hs = 0; cur_len = 0; beat = 0; b_pend = 0; done = 0;
      while (r > 0) begin
         words = (4096 - (a % 4096)) / 4;
         if (r < words) words = r;
         exp_aw.push_back(a);
         exp_len.push_back(words - 1);
         a += words * 4;
         r -= words;
      end
      for (int i = 0; i < len; i++) begin
         logic [31:0] d;
         d = $urandom;
         src.push_back(d);
         exp_d.push_back(d);
      end
      @(negedge clk_i);
      idle_inputs();
      w_addr_i = addr;
      w_length_i = len[8:0];
      w_start_transfer_i = 1'b1;
      @(negedge clk_i);
      w_start_transfer_i = 1'b0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         if (cyc > 0) @(negedge clk_i);
         w_start_transfer_i = mid_start && (cyc == 3);
         if (mid_start && cyc == 3) begin
            w_addr_i = 32'h2000;
            w_length_i = 9'd3;
         end
         axi_awready_i   = ($urandom_range(0, 99) >= gap);
         axi_wready_i    = ($urandom_range(0, 99) >= gap);
         axis_in_valid_i = (src.size() > 0) && ($urandom_range(0, 99) >= gap);
         axis_in_data_i  = (src.size() > 0) ? src[0] : 32'h0;
         axi_bvalid_i    = b_pend;
         axi_bresp_i     = bresp_v;
         #1;
         if (cyc == 0) begin
            chk("busy_after_start", w_busy_o, 1);
            chk("error_cleared_on_start", w_error_o, 0);
         end
         if (!w_busy_o) begin
            done = 1;
            break;
         end
         if (axi_awvalid_o && axi_awready_i) begin
            if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
            else begin
               chk("aw_addr", axi_awaddr_o, exp_aw.pop_front());
               cur_len = exp_len.pop_front();
               chk("aw_len", axi_awlen_o, cur_len);
               beat = 0;
            end
         end
         if (axi_wvalid_o && axi_wready_i) begin
            if (exp_d.size() == 0) chk("w_unexpected", 1, 0);
            else begin
               chk("w_data", axi_wdata_o, exp_d.pop_front());
               chk("w_last", axi_wlast_o, (beat == cur_len));
            end
            if (axi_wlast_o) b_pend = 1;
            beat++;
            hs++;
            if (src.size() > 0) void'(src.pop_front());
         end
         if (axi_bvalid_i && axi_bready_o) b_pend = 0;
         if (rst_beat > 0 && hs == rst_beat) break;
      end
      if (rst_beat > 0) begin
         chk("beats_before_reset", hs, rst_beat);
         @(negedge clk_i);
         rst_i = 1'b1;
         @(negedge clk_i);
         rst_i = 1'b0;
         axis_in_valid_i = 1'b1;
         axi_wready_i = 1'b1;
         #1;
         chk("rst_busy", w_busy_o, 0);
         chk("rst_awvalid", axi_awvalid_o, 0);
         chk("rst_axis_ready", axis_in_ready_o, 0);
         chk("rst_wvalid", axi_wvalid_o, 0);
         chk("rst_bready", axi_bready_o, 0);
         exp_aw.delete(); exp_len.delete(); exp_d.delete(); src.delete();
         idle_inputs();
      end else begin
         chk("xfer_done", done, 1);
         chk("handshakes", hs, len);
         chk("aw_left", exp_aw.size(), 0);
         chk("data_left", exp_d.size(), 0);
         chk("error_after", w_error_o, (bresp_v != 2'b00));
      end
   endtask

   initial begin
      cke_i = 1'b1;
      rst_i = 1'b1;
      w_addr_i = '0;
      w_length_i = '0;
      axi_bid_i = '0;
      idle_inputs();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("reset_busy", w_busy_o, 0);
      chk("reset_error", w_error_o, 0);
      chk("reset_awvalid", axi_awvalid_o, 0);
      chk("reset_awaddr", axi_awaddr_o, 0);
      chk("reset_bready", axi_bready_o, 0);
      chk("reset_axis_ready", axis_in_ready_o, 0);
      chk("awsize", axi_awsize_o, 3'd2);
      chk("awburst", axi_awburst_o, 2'd1);
      chk("awcache", axi_awcache_o, 4'd2);
      chk("awlock", axi_awlock_o, 0);
      chk("awqos", axi_awqos_o, 0);
      chk("awid", axi_awid_o, 0);
      chk("wstrb", axi_wstrb_o, 4'hF);

      xfer(32'h100, 4, 0, 2'b00, 0, 0);
      xfer(32'hFF8, 8, 0, 2'b00, 0, 0);
      xfer(32'h0, 256, 30, 2'b00, 1, 0);
      xfer(32'h400, 4, 0, 2'b10, 0, 0);
      xfer(32'h800, 3, 20, 2'b00, 0, 0);

      // A zero-length start is ignored.
      @(negedge clk_i);
      w_addr_i = 32'h300;
      w_length_i = 9'd0;
      w_start_transfer_i = 1'b1;
      @(negedge clk_i);
      w_start_transfer_i = 1'b0;
      #1;
      chk("len0_busy", w_busy_o, 0);
      chk("len0_awvalid", axi_awvalid_o, 0);

      // With the clock enable low a start has no effect.
      @(negedge clk_i);
      cke_i = 1'b0;
      w_length_i = 9'd4;
      w_start_transfer_i = 1'b1;
      @(negedge clk_i);
      w_start_transfer_i = 1'b0;
      cke_i = 1'b1;
      #1;
      chk("cke_low_busy", w_busy_o, 0);
      chk("cke_low_awvalid", axi_awvalid_o, 0);

      xfer(32'h40, 8, 0, 2'b00, 0, 2);
      xfer(32'h200, 2, 0, 2'b00, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
